// File: rtl/fila_pkg.sv
// Shared defaults, widths and enqueue FSM states for the fila queue.
`timescale 1ns/1ps
package fila_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned PTR_W_DEF  = $clog2(DEPTH_DEF);
    localparam int unsigned LEN_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RELEASE = 2'd2
    } enq_state_t;

endpackage

// File: rtl/fila_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
`timescale 1ns/1ps
module fila_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fila.sv
// FIFO queue with level-handshake enqueue FSM and edge-triggered dequeue.
// Define FILA_PEEK_EN to make data_out track the head element continuously.
`timescale 1ns/1ps
module fila
    import fila_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    output logic [DATA_W-1:0] data_out,
    output logic [LEN_W-1:0]  len_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

    enq_state_t        state, state_nx;
    logic              capture_c;
    logic [PTR_W-1:0]  head, tail, head_nx, raddr_c;
    logic [LEN_W-1:0]  len_nx;
    logic              deq_prev;
    logic              empty_c, full_c, deq_c, wr_c;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // One write per high level of enqueue_in; RELEASE waits for it to drop.
    always_comb begin
        state_nx  = state;
        capture_c = 1'b0;
        case (state)
            IDLE:    if (enqueue_in) state_nx = CAPTURE;
            CAPTURE: begin
                capture_c = 1'b1;
                state_nx  = RELEASE;
            end
            RELEASE: if (!enqueue_in) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Dequeue is resolved before the write, so a full queue still accepts a write on a dequeue edge.
    assign empty_c = (len_out == '0);
    assign full_c  = (len_out == LEN_FULL);
    assign deq_c   = dequeue_in && !deq_prev && !empty_c;
    assign wr_c    = capture_c && (!full_c || deq_c);

    always_comb begin
        head_nx = deq_c ? head + PTR_W'(1) : head;
        len_nx  = len_out;
        if (wr_c && !deq_c) begin
            len_nx = len_out + LEN_W'(1);
        end else if (deq_c && !wr_c) begin
            len_nx = len_out - LEN_W'(1);
        end
    end

`ifdef FILA_PEEK_EN
    assign raddr_c = head_nx;
`else
    assign raddr_c = head;
`endif

    fila_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk_10KHz),
        .we    (wr_c),
        .waddr (tail),
        .wdata (data_in),
        .raddr (raddr_c),
        .rdata (rd_data)
    );

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            len_out  <= '0;
            deq_prev <= 1'b0;
            data_out <= '0;
        end else begin
            deq_prev <= dequeue_in;
            head     <= head_nx;
            len_out  <= len_nx;
            if (wr_c) begin
                tail <= tail + PTR_W'(1);
            end
`ifdef FILA_PEEK_EN
            // Writing into an empty queue makes the incoming word the new head.
            if (len_nx == '0) begin
                data_out <= '0;
            end else if (empty_c) begin
                data_out <= data_in;
            end else begin
                data_out <= rd_data;
            end
`else
            if (deq_c) begin
                data_out <= rd_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fila.sv
// Directed bench for fila: queue-based reference model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_fila;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic          clk_10KHz = 1'b0;
    logic          reset     = 1'b1;
    logic [DW-1:0] data_in   = '0;
    logic          enqueue_in = 1'b0;
    logic          dequeue_in = 1'b0;
    logic [DW-1:0] data_out;
    logic [7:0]    len_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_10KHz = ~clk_10KHz;

    fila #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_10KHz  (clk_10KHz),
        .reset      (reset),
        .data_in    (data_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .len_out    (len_out)
    );

    // Reference: a queue; writes land one edge after an accepted enqueue level, dequeues on rising dequeue_in.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    bit            m_deq_prev, m_write_now, m_wait_low;

    always @(posedge clk_10KHz or posedge reset) begin
        bit do_deq;
        if (reset) begin
            m_q.delete();
            m_dout      = '0;
            m_deq_prev  = 1'b0;
            m_write_now = 1'b0;
            m_wait_low  = 1'b0;
        end else begin
            do_deq = dequeue_in && !m_deq_prev && (m_q.size() > 0);
            if (do_deq) m_dout = m_q.pop_front();
            if (m_write_now && m_q.size() < DEPTH) m_q.push_back(data_in);
            if (m_write_now) begin
                m_write_now = 1'b0;
                m_wait_low  = 1'b1;
            end else if (m_wait_low) begin
                if (!enqueue_in) m_wait_low = 1'b0;
            end else if (enqueue_in) begin
                m_write_now = 1'b1;
            end
            m_deq_prev = dequeue_in;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_10KHz) begin
        check("model_len", len_out, 8'(m_q.size()));
        check("model_dout", data_out, m_dout);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_10KHz);
        #1;
    endtask

    task automatic enq(input logic [DW-1:0] d);
        data_in    = d;
        enqueue_in = 1'b1;
        tick(2);
        enqueue_in = 1'b0;
        data_in    = 8'hEE;
        tick(1);
    endtask

    task automatic deq_pulse();
        dequeue_in = 1'b1;
        tick(1);
        dequeue_in = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check("reset_len", len_out, 8'h00);
        check("reset_dout", data_out, 8'h00);
        reset = 1'b0;
        tick(1);

        // Fill with 0x11..0x88
        for (int i = 1; i <= 8; i++) begin
            enq(8'(i * 17));
            check("fill_len", len_out, 8'(i));
        end

        // Write while full is dropped
        enq(8'h99);
        check("full_len", len_out, 8'd8);

        // Drain with enqueue_in held high
        data_in    = 8'h55;
        enqueue_in = 1'b1;
        tick(3);
        for (int i = 1; i <= 9; i++) begin
            deq_pulse();
            check("drain_dout", data_out, 8'(((i > 8) ? 8 : i) * 17));
            check("drain_len", len_out, 8'((i > 8) ? 0 : 8 - i));
        end
        enqueue_in = 1'b0;
        data_in    = 8'h00;
        tick(2);
        check("empty_hold_len", len_out, 8'd0);

        // Held dequeue_in counts once
        enq(8'hA1);
        enq(8'hA2);
        enq(8'hA3);
        dequeue_in = 1'b1;
        tick(5);
        check("held_deq_len", len_out, 8'd2);
        check("held_deq_dout", data_out, 8'hA1);
        dequeue_in = 1'b0;
        tick(1);
        deq_pulse();
        check("held_next_dout", data_out, 8'hA2);
        deq_pulse();
        check("held_last_dout", data_out, 8'hA3);
        check("held_last_len", len_out, 8'd0);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 10; i++) begin
            enq(8'(8'h20 + i));
            if (i >= 1 && i <= 6) deq_pulse();
        end
        check("wrap_len", len_out, 8'd4);
        check("wrap_dout", data_out, 8'h25);
        for (int i = 10; i < 14; i++) enq(8'(8'h20 + i));
        check("wrap_full_len", len_out, 8'd8);

        // Simultaneous write and dequeue while full
        data_in    = 8'h2E;
        enqueue_in = 1'b1;
        tick(1);
        dequeue_in = 1'b1;
        tick(1);
        check("simul_dout", data_out, 8'h26);
        check("simul_len", len_out, 8'd8);
        dequeue_in = 1'b0;
        enqueue_in = 1'b0;
        tick(1);
        deq_pulse();
        check("post_simul_dout", data_out, 8'h27);
        for (int i = 0; i < 7; i++) deq_pulse();
        check("wrap_tail_dout", data_out, 8'h2E);
        check("wrap_tail_len", len_out, 8'd0);

        // Reset released with enqueue_in already high
        reset      = 1'b1;
        data_in    = 8'h3C;
        enqueue_in = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        check("rst_enq_len", len_out, 8'd1);
        enqueue_in = 1'b0;
        tick(1);
        deq_pulse();
        check("rst_enq_dout", data_out, 8'h3C);

        // Reset during a handshake with five stored
        for (int i = 1; i <= 5; i++) enq(8'(8'h60 + i));
        check("pre_rst_len", len_out, 8'd5);
        data_in    = 8'h77;
        enqueue_in = 1'b1;
        tick(1);
        reset = 1'b1;
        #1;
        check("async_rst_len", len_out, 8'd0);
        check("async_rst_dout", data_out, 8'd0);
        enqueue_in = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
        check("post_rst_len", len_out, 8'd0);
        enq(8'h5A);
        check("post_rst_enq_len", len_out, 8'd1);
        deq_pulse();
        check("post_rst_dout", data_out, 8'h5A);
        check("post_rst_final_len", len_out, 8'd0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fila.md
FILA -- requirements
Module: fila

Interface
REQ-001 Parameter DATA_W, default 8: width of each stored element and of data_in/data_out.
REQ-002 Parameter DEPTH, default 8: queue capacity in elements; power of two, 2..128.
REQ-003 clk_10KHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  DATA_W  element to enqueue.
REQ-006 enqueue_in  input  1  enqueue request, level, two-phase handshake (REQ-010..012).
REQ-007 dequeue_in  input  1  dequeue request, rising-edge triggered.
REQ-008 data_out  output  DATA_W  registered; last element removed from the queue.
REQ-009 len_out  output  8  registered; current element count, 0..DEPTH.

Function
REQ-010 The enqueue FSM SHALL have states IDLE, CAPTURE and RELEASE.
REQ-011 IDLE -> CAPTURE when enqueue_in=1; CAPTURE writes data_in (sampled this edge) at tail if not full, then -> RELEASE; RELEASE -> IDLE when enqueue_in=0.
REQ-012 Holding enqueue_in high SHALL produce exactly one write; a new write needs enqueue_in low for at least one edge.
REQ-013 A CAPTURE while full (len_out=DEPTH) SHALL discard data; FSM still -> RELEASE; contents and len_out unchanged.
REQ-014 A dequeue SHALL occur on an edge where dequeue_in=1 and its registered previous value was 0.
REQ-015 A dequeue with len_out>0 SHALL load data_out with the head element and advance head, one-cycle latency.
REQ-016 A dequeue with len_out=0 SHALL be ignored; data_out and len_out hold.
REQ-017 Dequeue SHALL be independent of FSM state (allowed while enqueue_in is held high).
REQ-018 Write and dequeue on the same edge: dequeue first, write allowed even if full before the edge; len_out unchanged.
REQ-019 Head/tail pointers SHALL wrap modulo DEPTH; order strictly FIFO across wrap.
REQ-020 len_out SHALL be +1 on accepted write, -1 on accepted dequeue, never outside 0..DEPTH.

Reset
REQ-021 Reset SHALL force: data_out=0, len_out=0, pointers=0, FSM=IDLE, dequeue edge register=0.
REQ-022 Reset mid-operation SHALL abandon any pending capture; storage array need not be cleared.
REQ-023 After reset deassert with enqueue_in already high, FSM SHALL enter CAPTURE on the next edge.

Configuration
REQ-024 Macro FILA_PEEK_EN: when defined, data_out SHALL continuously show the current head element (0 when empty), combinationally from storage but registered output updated every edge; dequeue only discards.
REQ-025 Without FILA_PEEK_EN, data_out SHALL behave per REQ-015/016 only.

Structure
REQ-026 Package fila_pkg SHALL hold DATA_W/DEPTH defaults, the pointer width constant ($clog2(DEPTH)) and the FSM state enum.
REQ-027 One sub-module, fila_mem: DEPTH x DATA_W register array, one write port, one read port, no reset.

Verification
REQ-028 Reset then 8 enqueue handshakes of 0x11..0x88 (data changed one cycle after enqueue_in rises) -> len_out 1..8, no value 0x00 stored.
REQ-029 Ninth handshake with 0x99 while full -> len_out stays 8, 0x99 never appears at data_out.
REQ-030 Nine one-cycle dequeue pulses with enqueue_in held high -> data_out 0x11,0x22..0x88 in order, len_out 7..0; ninth pulse leaves data_out=0x88, len_out=0.
REQ-031 dequeue_in held high 5 cycles with len_out=3 -> exactly one dequeue, len_out=2.
REQ-032 Enqueue 10 and dequeue 6 interleaved (pointer wrap), simultaneous write+dequeue when full -> FIFO order preserved, len_out stays 8.
REQ-033 Reset asserted during CAPTURE/RELEASE with len_out=5 -> len_out=0, data_out=0 immediately, next handshake stores at position 0.
